mod_seq_ctrl: RTL and testbench

- FSM controller that sequences the 32-bit repeated-subtraction modulo datapath. Its ld/mux outputs drive that datapath, and it consumes the datapath's b_less compare flag.
- Provides a start/done handshake to the surrounding logic and a quotient (subtraction count).
- Rejects B==0 up front instead of letting the datapath loop forever.

---
 rtl/mod_seq_ctrl.sv | 58 +++++
 tb/tb_mod_seq_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mod_seq_ctrl.sv
// mod_seq_ctrl: FSM sequencing a repeated-subtraction modulo datapath with start/done handshake and quotient count.
// Optional MOD_TIMEOUT_EN aborts with err once quotient reaches MAX_ITER.
module mod_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] MAX_ITER = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] B,
   input  logic             b_less,
   output logic             ld,
   output logic             mux,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] quotient
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] CHECK = 3'd2;
   localparam logic [2:0] SUB   = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;
   localparam logic [2:0] ERR   = 3'd5;
   logic [2:0] state, nxt;
   logic       sub_go;
`ifdef MOD_TIMEOUT_EN
   assign sub_go = quotient != MAX_ITER;
`else
   logic unused_max;
   assign unused_max = ^MAX_ITER;
   assign sub_go = 1'b1;
`endif
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = start ? ((B == '0) ? ERR : LOAD) : IDLE;
         LOAD:    nxt = CHECK;
         CHECK:   nxt = b_less ? DONE : (sub_go ? SUB : ERR);
         SUB:     nxt = CHECK;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         quotient <= '0;
      end else begin
         state    <= nxt;
         quotient <= (state == LOAD) ? '0 : (state == SUB) ? quotient + 1'b1 : quotient;
      end
   end
   assign ld   = (state == LOAD) || (state == SUB);
   assign mux  = state == SUB;
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign err  = state == ERR;
endmodule

// File: tb/tb_mod_seq_ctrl.sv
// tb_mod_seq_ctrl: randomized and directed checks of mod_seq_ctrl driving a behavioural subtract datapath.
// Expected results come from integer division/modulo on the operands.
module tb_mod_seq_ctrl;
`ifdef MOD_TIMEOUT_EN
   localparam logic [31:0] MAXP = 32'd4;
`else
   localparam logic [31:0] MAXP = 32'hFFFF_FFFF;
`endif
   logic clk = 0, rst = 1, start = 0, b_less;
   logic [31:0] aa = 0, bb = 0, quotient, dreg = 0;
   logic ld, mux, busy, done, err;
   int n_cmp = 0, n_fail = 0;
   int done_cyc, err_cyc, n_done, n_err, ld_cnt;
   logic [31:0] q_at, r_at, q_after;
   logic busy_after;
   logic ld_log [0:63];
   logic mux_log [0:63];

   mod_seq_ctrl #(.WIDTH(32), .MAX_ITER(MAXP)) dut (
      .clk(clk), .rst(rst), .start(start), .B(bb), .b_less(b_less),
      .ld(ld), .mux(mux), .busy(busy), .done(done), .err(err), .quotient(quotient)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (ld) dreg <= mux ? dreg - bb : aa;
   assign b_less = dreg < bb;

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int budget, input int p1, input int p2);
      int cyc;
      aa = a; bb = b; start = 1;
      for (int i = 0; i < 64; i++) begin ld_log[i] = 0; mux_log[i] = 0; end
      @(posedge clk); #1 start = 0;
      cyc = 1; done_cyc = -1; err_cyc = -1; n_done = 0; n_err = 0; ld_cnt = 0; q_at = 'x; r_at = 'x;
      while (done_cyc < 0 && err_cyc < 0 && cyc <= budget) begin
         if (cyc < 64) begin ld_log[cyc] = ld; mux_log[cyc] = mux; end
         if (ld) ld_cnt++;
         if (done) begin done_cyc = cyc; n_done++; q_at = quotient; r_at = dreg; end
         if (err) begin err_cyc = cyc; n_err++; q_at = quotient; r_at = dreg; end
         start = (cyc == p1) || (cyc == p2);
         @(posedge clk); #1 cyc++;
      end
      start = 0;
      busy_after = busy;
      for (int i = 0; i < 3; i++) begin
         if (done) n_done++;
         if (err) n_err++;
         if (ld) ld_cnt++;
         @(posedge clk); #1;
      end
      q_after = quotient;
   endtask

   task automatic test_reset();
      rst = 1; start = 0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, ld, mux, done, err} !== 5'b0 || quotient !== 0) begin
         n_fail++;
         $display("FAIL reset_state got outs=%b q=%0d want outs=00000 q=0", {busy, ld, mux, done, err}, quotient);
      end
      rst = 0;
      aa = 100; bb = 3; start = 1;
      @(posedge clk); #1 start = 0;
      repeat (4) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      n_cmp++;
      if (busy !== 0 || ld !== 0 || quotient !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_op got busy=%b ld=%b q=%0d want 0 0 0", busy, ld, quotient);
      end
      do_op(7, 3, 40, 0, 0);
      n_cmp++;
      if (done_cyc !== 7 || q_at !== 2 || r_at !== 1) begin
         n_fail++;
         $display("FAIL reset_followup got cyc=%0d q=%0d r=%0d want 7 2 1", done_cyc, q_at, r_at);
      end
   endtask

   task automatic test_basic();
      logic exp_ld [1:6];
      exp_ld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      do_op(7, 3, 40, 0, 0);
      for (int i = 1; i <= 6; i++) begin
         n_cmp++;
         if (ld_log[i] !== exp_ld[i] || (exp_ld[i] && mux_log[i] !== (i != 1))) begin
            n_fail++;
            $display("FAIL basic_seq cyc%0d got ld=%b mux=%b want ld=%b mux=%b", i, ld_log[i], mux_log[i], exp_ld[i], i != 1);
         end
      end
      n_cmp++;
      if (done_cyc !== 7 || q_at !== 2 || r_at !== 1 || busy_after !== 0 || n_done !== 1) begin
         n_fail++;
         $display("FAIL basic_result got cyc=%0d q=%0d r=%0d busy_after=%b ndone=%0d want 7 2 1 0 1", done_cyc, q_at, r_at, busy_after, n_done);
      end
   endtask

   task automatic test_a_lt_b();
      do_op(2, 5, 40, 0, 0);
      n_cmp++;
      if (done_cyc !== 3 || q_at !== 0 || r_at !== 2 || ld_cnt !== 1) begin
         n_fail++;
         $display("FAIL a_lt_b got cyc=%0d q=%0d r=%0d ld_cnt=%0d want 3 0 2 1", done_cyc, q_at, r_at, ld_cnt);
      end
   endtask

   task automatic test_exact_and_zero();
      do_op(12, 4, 40, 0, 0);
      n_cmp++;
      if (done_cyc !== 9 || q_at !== 3 || r_at !== 0) begin
         n_fail++;
         $display("FAIL exact_multiple got cyc=%0d q=%0d r=%0d want 9 3 0", done_cyc, q_at, r_at);
      end
      do_op(9, 0, 40, 0, 0);
      n_cmp++;
      if (err_cyc !== 1 || ld_cnt !== 0 || n_done !== 0 || n_err !== 1 || q_after !== 3) begin
         n_fail++;
         $display("FAIL div_zero got err_cyc=%0d ld_cnt=%0d ndone=%0d nerr=%0d q=%0d want 1 0 0 1 3", err_cyc, ld_cnt, n_done, n_err, q_after);
      end
   endtask

   task automatic test_busy_start();
      do_op(20, 1, 100, 4, 10);
      n_cmp++;
      if (done_cyc !== 43 || q_at !== 20 || r_at !== 0 || n_done !== 1) begin
         n_fail++;
         $display("FAIL busy_start got cyc=%0d q=%0d r=%0d ndone=%0d want 43 20 0 1", done_cyc, q_at, r_at, n_done);
      end
   endtask

`ifdef MOD_TIMEOUT_EN
   task automatic test_timeout();
      do_op(50, 5, 60, 0, 0);
      n_cmp++;
      if (err_cyc !== 11 || q_after !== 4 || n_done !== 0 || n_err !== 1 || dreg !== 30) begin
         n_fail++;
         $display("FAIL timeout got err_cyc=%0d q=%0d ndone=%0d nerr=%0d r=%0d want 11 4 0 1 30", err_cyc, q_after, n_done, n_err, dreg);
      end
   endtask
`endif

   task automatic test_random();
      longint last_q = 0, q, r, exp_cyc, lim;
      logic [31:0] a, b;
      logic exp_err;
      lim = longint'(MAXP);
      for (int i = 0; i < 30; i++) begin
         if (i > 0 && $urandom_range(0, 5) == 0) begin
            b = 0;
            a = $urandom;
         end else begin
            b = $urandom_range(1, 1000);
            a = b * $urandom_range(0, 12) + $urandom_range(0, b - 1);
         end
         if (b == 0) begin
            exp_err = 1; exp_cyc = 1; q = last_q; r = 0;
         end else if (a / b > lim) begin
            exp_err = 1; q = lim; exp_cyc = 2 * lim + 3; r = a - lim * b;
         end else begin
            exp_err = 0; q = a / b; exp_cyc = 2 * q + 3; r = a % b;
         end
         last_q = q;
         do_op(a, b, 40, 0, 0);
         n_cmp++;
         if (exp_err ? (err_cyc != exp_cyc || n_done != 0 || q_at !== q[31:0] || (b != 0 && r_at !== r[31:0]))
                     : (done_cyc != exp_cyc || n_err != 0 || q_at !== q[31:0] || r_at !== r[31:0])) begin
            n_fail++;
            $display("FAIL random%0d a=%0d b=%0d got done=%0d err=%0d q=%0d r=%0d want cyc=%0d err=%b q=%0d r=%0d",
                     i, a, b, done_cyc, err_cyc, q_at, r_at, exp_cyc, exp_err, q, r);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_a_lt_b();
      test_exact_and_zero();
      test_busy_start();
`ifdef MOD_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
